// File: rtl/top_k_collector.sv
// Collects the held values of a top-k chain after a TLAST, streams them out
// over AXI-stream, then injects a clear marker into the chain head.
module top_k_collector #(
  parameter int INTEGER_SIZE = 32,
  parameter int K            = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [K*INTEGER_SIZE-1:0] reg_TDATA,
  input  logic [K-1:0]              reg_TVALID,
  input  logic                      chain_TVALID,
  input  logic                      chain_TLAST,
  output logic                      chain_TREADY,
  output logic [INTEGER_SIZE-1:0]   result_TDATA,
  output logic                      result_TVALID,
  output logic                      result_TLAST,
  input  logic                      result_TREADY,
  output logic [INTEGER_SIZE:0]     flush_TDATA,
  output logic                      flush_TVALID,
  input  logic                      flush_TREADY,
  output logic [15:0]               sets_done
);

  localparam int CW = $clog2(K + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, WAIT} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             idx_q, idx_d;
  logic [CW-1:0]             count_q, count_d;
  logic [K*INTEGER_SIZE-1:0] snap_q, snap_d;
  logic [15:0]               sets_q, sets_d;
  logic [CW-1:0]             lead_ones;
  logic                      run;
  logic [INTEGER_SIZE-1:0]   word;
  logic                      last_beat;

  // Only the unbroken run of valid units from the head counts.
  always_comb begin
    lead_ones = '0;
    run       = 1'b1;
    for (int unsigned i = 0; i < K; i++) begin
      run = run & reg_TVALID[i];
      if (run) lead_ones = CW'(i + 1);
    end
  end

  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (idx_q == CW'(i)) word = snap_q[i*INTEGER_SIZE +: INTEGER_SIZE];
    end
  end

  assign last_beat = (count_q == '0) || (idx_q == count_q - CW'(1));
  assign sets_done = sets_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      count_q <= '0;
      snap_q  <= '0;
      sets_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      snap_q  <= snap_d;
      sets_q  <= sets_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    count_d       = count_q;
    snap_d        = snap_q;
    sets_d        = sets_q;
    chain_TREADY  = 1'b0;
    result_TVALID = 1'b0;
    result_TLAST  = 1'b0;
    result_TDATA  = '0;
    flush_TVALID  = 1'b0;
    flush_TDATA   = '0;
    case (state_q)
      IDLE: begin
        chain_TREADY = 1'b1;
        if (chain_TVALID && chain_TLAST) begin
          snap_d  = reg_TDATA;
          count_d = lead_ones;
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        result_TVALID = 1'b1;
        result_TLAST  = last_beat;
        // An empty set still produces one zero beat so the consumer sees TLAST.
        result_TDATA  = (count_q == '0) ? '0 : word;
        if (result_TREADY) begin
          if (last_beat) begin
            idx_d   = '0;
            sets_d  = sets_q + 16'd1;
            state_d = FLUSH;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      FLUSH: begin
        flush_TVALID = 1'b1;
        flush_TDATA  = {1'b1, {INTEGER_SIZE{1'b0}}};
        if (flush_TREADY) state_d = WAIT;
      end
      WAIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_top_k_collector.sv
// Self-checking bench for top_k_collector (K=4): directed sets plus randomized
// sets checked against a queue-based model of the leading-valid rule.
module tb_top_k_collector;

  localparam int W  = 32;
  localparam int KK = 4;
  localparam logic [W:0] FLUSH_WORD = {1'b1, {W{1'b0}}};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [KK*W-1:0]   reg_TDATA = '0;
  logic [KK-1:0]     reg_TVALID = '0;
  logic              chain_TVALID = 1'b0;
  logic              chain_TLAST = 1'b0;
  logic              chain_TREADY;
  logic [W-1:0]      result_TDATA;
  logic              result_TVALID;
  logic              result_TLAST;
  logic              result_TREADY = 1'b0;
  logic [W:0]        flush_TDATA;
  logic              flush_TVALID;
  logic              flush_TREADY = 1'b0;
  logic [15:0]       sets_done;

  always #5 clk = ~clk;

  top_k_collector #(.INTEGER_SIZE(W), .K(KK)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_TDATA    (reg_TDATA),
    .reg_TVALID   (reg_TVALID),
    .chain_TVALID (chain_TVALID),
    .chain_TLAST  (chain_TLAST),
    .chain_TREADY (chain_TREADY),
    .result_TDATA (result_TDATA),
    .result_TVALID(result_TVALID),
    .result_TLAST (result_TLAST),
    .result_TREADY(result_TREADY),
    .flush_TDATA  (flush_TDATA),
    .flush_TVALID (flush_TVALID),
    .flush_TREADY (flush_TREADY),
    .sets_done    (sets_done)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_sets = '0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_d[$];
  bit           obs_l[$];
  int           proto_err;
  int           cycles;
  bit           timed_out;

  task automatic model_set(input logic [KK*W-1:0] data, input logic [KK-1:0] valid);
    exp_q.delete();
    for (int i = 0; i < KK; i++) begin
      if (!valid[i]) break;
      exp_q.push_back(data[i*W +: W]);
    end
    if (exp_q.size() == 0) exp_q.push_back('0);
  endtask

  task automatic capture(input logic [KK*W-1:0] data, input logic [KK-1:0] valid);
    n_checks++;
    if (chain_TREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL capture_ready: chain_TREADY=%b expected 1", chain_TREADY);
    end
    reg_TDATA    = data;
    reg_TVALID   = valid;
    chain_TVALID = 1'b1;
    chain_TLAST  = 1'b1;
    @(negedge clk);
    chain_TVALID = 1'b0;
    chain_TLAST  = 1'b0;
  endtask

  // mode 0: ready always; 1: ready pattern 1,0,0,1; 2: random ready
  task automatic drain(input int mode, input bit scramble);
    logic [W-1:0] held_d;
    bit           held_l;
    bit           stalled;
    bit           done;
    bit           r;
    obs_d.delete();
    obs_l.delete();
    proto_err = 0;
    cycles    = 0;
    timed_out = 1'b1;
    stalled   = 1'b0;
    held_d    = '0;
    held_l    = 1'b0;
    for (int c = 0; c < 200; c++) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ((c % 4) == 0) || ((c % 4) == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      result_TREADY = r;
      if (scramble && c == 1) begin
        reg_TDATA    = {$urandom, $urandom, $urandom, $urandom};
        reg_TVALID   = 4'($urandom);
        chain_TVALID = 1'b1;
        chain_TLAST  = 1'b1;
      end
      cycles++;
      done = 1'b0;
      if (result_TVALID !== 1'b1 || chain_TREADY !== 1'b0 || flush_TVALID !== 1'b0) begin
        proto_err++;
      end else begin
        if (stalled && (result_TDATA !== held_d || result_TLAST !== held_l)) proto_err++;
        if (r) begin
          obs_d.push_back(result_TDATA);
          obs_l.push_back(result_TLAST);
          stalled = 1'b0;
          done    = result_TLAST;
        end else begin
          stalled = 1'b1;
          held_d  = result_TDATA;
          held_l  = result_TLAST;
        end
      end
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    result_TREADY = 1'b0;
    chain_TVALID  = 1'b0;
    chain_TLAST   = 1'b0;
  endtask

  task automatic flush_phase(input string name, input int fstall);
    for (int c = 0; c <= fstall; c++) begin
      flush_TREADY = (c == fstall);
      n_checks++;
      if (flush_TVALID !== 1'b1 || flush_TDATA !== FLUSH_WORD || chain_TREADY !== 1'b0 ||
          result_TVALID !== 1'b0) begin
        n_fail++;
        $display("FAIL %s flush[%0d]: flush_TVALID=%b flush_TDATA=%h chain_TREADY=%b result_TVALID=%b expected 1/%h/0/0",
                 name, c, flush_TVALID, flush_TDATA, chain_TREADY, result_TVALID, FLUSH_WORD);
      end
      @(negedge clk);
    end
    flush_TREADY = 1'b0;
    n_checks++;
    if (flush_TVALID !== 1'b0 || chain_TREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL %s wait: flush_TVALID=%b chain_TREADY=%b expected 0/0", name, flush_TVALID, chain_TREADY);
    end
    @(negedge clk);
    n_checks++;
    if (chain_TREADY !== 1'b1 || flush_TVALID !== 1'b0 || result_TVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_return: chain_TREADY=%b flush_TVALID=%b result_TVALID=%b expected 1/0/0",
               name, chain_TREADY, flush_TVALID, result_TVALID);
    end
  endtask

  task automatic run_set(input string name, input logic [KK*W-1:0] data, input logic [KK-1:0] valid,
                         input int mode, input bit scramble, input int fstall);
    model_set(data, valid);
    capture(data, valid);
    drain(mode, scramble);
    n_checks++;
    if (timed_out || proto_err != 0) begin
      n_fail++;
      $display("FAIL %s drain_protocol: timeout=%0b violations=%0d expected 0/0", name, timed_out, proto_err);
    end
    n_checks++;
    if (obs_d.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s beat_count: got %0d expected %0d", name, obs_d.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_d.size(); i++) begin
      n_checks++;
      if (obs_d[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s word[%0d]: got %0d expected %0d", name, i, obs_d[i], exp_q[i]);
      end
      n_checks++;
      if (obs_l[i] !== (i == exp_q.size() - 1)) begin
        n_fail++;
        $display("FAIL %s tlast[%0d]: got %0b expected %0b", name, i, obs_l[i], (i == exp_q.size() - 1));
      end
    end
    if (mode == 0) begin
      n_checks++;
      if (cycles != exp_q.size()) begin
        n_fail++;
        $display("FAIL %s latency: drain took %0d cycles expected %0d", name, cycles, exp_q.size());
      end
    end
    exp_sets = exp_sets + 16'd1;
    n_checks++;
    if (sets_done !== exp_sets) begin
      n_fail++;
      $display("FAIL %s sets_done: got %0d expected %0d", name, sets_done, exp_sets);
    end
    flush_phase(name, fstall);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (result_TVALID !== 1'b0 || result_TLAST !== 1'b0 || result_TDATA !== '0 ||
        flush_TVALID !== 1'b0 || flush_TDATA !== '0 || chain_TREADY !== 1'b1 || sets_done !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: rv=%b rl=%b rd=%h fv=%b fd=%h cr=%b sets=%0d expected 0/0/0/0/0/1/0",
               result_TVALID, result_TLAST, result_TDATA, flush_TVALID, flush_TDATA, chain_TREADY, sets_done);
    end
    rst_n = 1'b1;
    exp_sets = '0;
    @(negedge clk);
  endtask

  task automatic test_ignore_no_last();
    reg_TVALID   = 4'b1111;
    chain_TVALID = 1'b1;
    chain_TLAST  = 1'b0;
    @(negedge clk);
    chain_TVALID = 1'b0;
    n_checks++;
    if (chain_TREADY !== 1'b1 || result_TVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_no_last: chain_TREADY=%b result_TVALID=%b expected 1/0", chain_TREADY, result_TVALID);
    end
  endtask

  task automatic test_basic();
    run_set("basic", {32'd10, 32'd40, 32'd70, 32'd90}, 4'b1111, 0, 1'b0, 0);
  endtask

  task automatic test_partial();
    run_set("partial", {$urandom, $urandom, 32'd3, 32'd5}, 4'b0011, 0, 1'b0, 0);
    run_set("gap", {32'd4, 32'd8, 32'd6, 32'd77}, 4'b1101, 0, 1'b0, 1);
  endtask

  task automatic test_empty();
    run_set("empty", {32'd1, 32'd2, 32'd3, 32'd4}, 4'b0000, 0, 1'b0, 0);
    run_set("head_invalid", {32'd9, 32'd8, 32'd7, 32'd6}, 4'b1110, 0, 1'b0, 0);
  endtask

  task automatic test_stall_scramble();
    run_set("stall_scramble", {32'd400, 32'd300, 32'd200, 32'd100}, 4'b1111, 1, 1'b1, 0);
  endtask

  task automatic test_flush_stall();
    run_set("flush_stall", {32'd44, 32'd33, 32'd22, 32'd11}, 4'b0111, 0, 1'b0, 5);
  endtask

  task automatic test_reset_mid_drain();
    capture({32'd1, 32'd2, 32'd3, 32'd4}, 4'b1111);
    result_TREADY = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_sets = '0;
    n_checks++;
    if (result_TVALID !== 1'b0 || result_TLAST !== 1'b0 || chain_TREADY !== 1'b1 || sets_done !== exp_sets) begin
      n_fail++;
      $display("FAIL reset_mid_drain: rv=%b rl=%b cr=%b sets=%0d expected 0/0/1/%0d",
               result_TVALID, result_TLAST, chain_TREADY, sets_done, exp_sets);
    end
    @(negedge clk);
    n_checks++;
    if (result_TVALID !== 1'b0 || chain_TREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_drain_idle: rv=%b cr=%b expected 0/1", result_TVALID, chain_TREADY);
    end
    run_set("after_reset", {32'd13, 32'd12, 32'd11, 32'd10}, 4'b1111, 0, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      run_set("random", {$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)),
              2, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_ignore_no_last();
    test_basic();
    test_partial();
    test_empty();
    test_stall_scramble();
    test_flush_stall();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
